// File: rtl/pcie_fc_pkg.sv
// pcie_fc_pkg -- shared definitions for the PCIe flow-control request arbiter.
//   fc_type_e        : credit-type encoding of a request (posted write / non-posted read)
//   arb_state_e      : arbiter FSM states
//   FC_SEL_TX_AVAIL  : cfg_fc_sel code selecting "transmit credits available"
//   fc_need_t/fc_need: credits (PH/PD/NPH) consumed by one TLP
package pcie_fc_pkg;

  typedef enum logic {
    FC_NONPOSTED = 1'b0,
    FC_POSTED    = 1'b1
  } fc_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;

  // Lengths are evaluated at this width; wider LEN_WIDTH values are truncated.
  localparam int LEN_MAX_W = 16;
  localparam int NEED_W    = 16;

  typedef struct packed {
    logic [NEED_W-1:0] ph;
    logic [NEED_W-1:0] pd;
    logic [NEED_W-1:0] nph;
  } fc_need_t;

  // Posted: one header plus one data credit per started 16-byte block.
  // Non-posted read: one NP header, no data credits.
  function automatic fc_need_t fc_need(input logic typ, input logic [LEN_MAX_W-1:0] len);
    fc_need_t            n;
    logic [LEN_MAX_W:0]  sum;
    n   = '0;
    sum = {1'b0, len} + 17'd15;
    if (typ == FC_POSTED) begin
      n.ph = 16'd1;
      n.pd = NEED_W'(sum >> 4);
    end else begin
      n.nph = 16'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pcie_fc_arb_if.sv
// pcie_fc_arb_if -- request/grant bundle between the DMA requesters, the
// flow-control arbiter and the RQ mux.
//   s_req_valid/ready/type/len : per-port request handshake (type 1 = posted)
//   m_grant_valid/ready        : grant handshake toward the RQ mux
//   m_grant_port/type/len      : copy of the granted request
// Modports: master = arbiter side, slave = requesters + RQ mux side.
interface pcie_fc_arb_if #(
  parameter int PORTS     = 2,
  parameter int LEN_WIDTH = 13
);
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0]                s_req_valid;
  logic [PORTS-1:0]                s_req_ready;
  logic [PORTS-1:0]                s_req_type;
  logic [PORTS-1:0][LEN_WIDTH-1:0] s_req_len;

  logic                            m_grant_valid;
  logic                            m_grant_ready;
  logic [IW-1:0]                   m_grant_port;
  logic                            m_grant_type;
  logic [LEN_WIDTH-1:0]            m_grant_len;

  modport master (
    input  s_req_valid, s_req_type, s_req_len, m_grant_ready,
    output s_req_ready, m_grant_valid, m_grant_port, m_grant_type, m_grant_len
  );

  modport slave (
    output s_req_valid, s_req_type, s_req_len, m_grant_ready,
    input  s_req_ready, m_grant_valid, m_grant_port, m_grant_type, m_grant_len
  );
endinterface

// File: rtl/pcie_fc_rr_arb.sv
// pcie_fc_rr_arb -- combinational round-robin priority encoder.
//   req_i     : request vector
//   ptr_i     : last served index; search starts at ptr_i+1 (mod PORTS)
//   gnt_oh_o  : one-hot grant
//   gnt_idx_o : index of the granted bit
//   gnt_any_o : at least one request present
module pcie_fc_rr_arb #(
  parameter int PORTS = 2,
  parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [PORTS-1:0] gnt_oh_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             gnt_any_o
);

  // Walk from the farthest candidate back to ptr+1 so the last hit (the
  // nearest one after the pointer) is the one that sticks.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr_i) + k) % PORTS;
      if (req_i[idx]) begin
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IW'(idx);
        gnt_any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_fc_arb.sv
// pcie_fc_arb -- credit-aware round-robin arbiter for DMA requesters feeding
// a PCIe RQ interface. A request is only granted when the core's advertised
// transmit credits, minus credits already reserved by earlier grants that
// have not yet been transmitted, cover its need.
//   clk, rst_n           : clock, synchronous active-low reset
//   rq (master)          : per-port requests and the grant handshake
//   tx_done_valid/type/len : one pulse per transmitted TLP, releases its reservation
//   cfg_fc_ph/pd/nph     : transmit credits available from the PCIe core
//   cfg_fc_sel           : constant credit-report select (transmit available)
//   stat_fc_stall        : cycles spent with requests pending but none fundable
// Optional: define PCIE_FC_ARB_STATS_EN to build the stall counter; otherwise
// stat_fc_stall reads 0.
module pcie_fc_arb
  import pcie_fc_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int LEN_WIDTH  = 13,
  parameter int PEND_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcie_fc_arb_if.master        rq,
  input  logic                 tx_done_valid,
  input  logic                 tx_done_type,
  input  logic [LEN_WIDTH-1:0] tx_done_len,
  input  logic [7:0]           cfg_fc_ph,
  input  logic [11:0]          cfg_fc_pd,
  input  logic [7:0]           cfg_fc_nph,
  output logic [2:0]           cfg_fc_sel,
  output logic [31:0]          stat_fc_stall
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int AW = PEND_WIDTH + 1;

  arb_state_e                state_q, state_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             sel_port_q, sel_port_d;
  logic                      sel_type_q, sel_type_d;
  logic [LEN_WIDTH-1:0]      sel_len_q, sel_len_d;
  logic [PEND_WIDTH-1:0]     pend_ph_q, pend_ph_d;
  logic [PEND_WIDTH-1:0]     pend_pd_q, pend_pd_d;
  logic [PEND_WIDTH-1:0]     pend_nph_q, pend_nph_d;

  logic [AW-1:0]             avail_ph, avail_pd, avail_nph;
  fc_need_t [PORTS-1:0]      need_w;
  logic [PORTS-1:0]          elig;
  logic [PORTS-1:0]          gnt_oh;
  logic [IW-1:0]             gnt_idx;
  logic                      gnt_any;
  logic                      take;
  logic                      pick_type;
  logic [LEN_WIDTH-1:0]      pick_len;
  fc_need_t                  pick_need, add_need, rel_need;

  // Advertised minus reserved, floored at zero.
  function automatic logic [AW-1:0] avail_f(input logic [AW-1:0] cfg,
                                            input logic [PEND_WIDTH-1:0] pend);
    logic [AW-1:0] p;
    p = AW'(pend);
    return (cfg > p) ? (cfg - p) : '0;
  endfunction

  // pend + add - rel, floored at zero and saturating at the counter max.
  function automatic logic [PEND_WIDTH-1:0] pend_upd(input logic [PEND_WIDTH-1:0] p,
                                                      input logic [NEED_W-1:0] add,
                                                      input logic [NEED_W-1:0] rel);
    logic [33:0] s;
    s = 34'(p) + 34'(add);
    if (s <= 34'(rel)) return '0;
    s = s - 34'(rel);
    if (s > 34'({PEND_WIDTH{1'b1}})) return '1;
    return PEND_WIDTH'(s);
  endfunction

  assign avail_ph  = avail_f(AW'(cfg_fc_ph),  pend_ph_q);
  assign avail_pd  = avail_f(AW'(cfg_fc_pd),  pend_pd_q);
  assign avail_nph = avail_f(AW'(cfg_fc_nph), pend_nph_q);

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign need_w[p] = fc_need(rq.s_req_type[p], LEN_MAX_W'(rq.s_req_len[p]));
    assign elig[p]   = rq.s_req_valid[p]
                     && (32'(need_w[p].ph)  <= 32'(avail_ph))
                     && (32'(need_w[p].pd)  <= 32'(avail_pd))
                     && (32'(need_w[p].nph) <= 32'(avail_nph));
  end

  pcie_fc_rr_arb #(.PORTS(PORTS), .IW(IW)) u_rr (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  always_comb begin
    pick_type = 1'b0;
    pick_len  = '0;
    pick_need = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (gnt_oh[p]) begin
        pick_type = rq.s_req_type[p];
        pick_len  = rq.s_req_len[p];
        pick_need = need_w[p];
      end
    end
  end

  assign take     = (state_q == ST_IDLE) && gnt_any;
  assign add_need = take ? pick_need : '0;
  assign rel_need = tx_done_valid ? fc_need(tx_done_type, LEN_MAX_W'(tx_done_len)) : '0;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_any) state_d = ST_GRANT;
      ST_GRANT: if (rq.m_grant_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Grant fields come from the registered copy, so a requester
  // changing or dropping its request mid-grant has no effect.
  always_comb begin
    rq.m_grant_valid = (state_q == ST_GRANT);
    rq.m_grant_port  = sel_port_q;
    rq.m_grant_type  = sel_type_q;
    rq.m_grant_len   = sel_len_q;
    rq.s_req_ready   = '0;
    if (state_q == ST_GRANT && rq.m_grant_ready) rq.s_req_ready[sel_port_q] = 1'b1;
  end

  // Datapath next state
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    sel_port_d = sel_port_q;
    sel_type_d = sel_type_q;
    sel_len_d  = sel_len_q;
    if (take) begin
      sel_port_d = gnt_idx;
      sel_type_d = pick_type;
      sel_len_d  = pick_len;
    end
    if (state_q == ST_GRANT && rq.m_grant_ready) rr_ptr_d = sel_port_q;
    pend_ph_d  = pend_upd(pend_ph_q,  add_need.ph,  rel_need.ph);
    pend_pd_d  = pend_upd(pend_pd_q,  add_need.pd,  rel_need.pd);
    pend_nph_d = pend_upd(pend_nph_q, add_need.nph, rel_need.nph);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= IW'(PORTS - 1);
      sel_port_q <= '0;
      sel_type_q <= 1'b0;
      sel_len_q  <= '0;
      pend_ph_q  <= '0;
      pend_pd_q  <= '0;
      pend_nph_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      sel_port_q <= sel_port_d;
      sel_type_q <= sel_type_d;
      sel_len_q  <= sel_len_d;
      pend_ph_q  <= pend_ph_d;
      pend_pd_q  <= pend_pd_d;
      pend_nph_q <= pend_nph_d;
    end
  end

  assign cfg_fc_sel = FC_SEL_TX_AVAIL;

`ifdef PCIE_FC_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Counts only idle cycles where someone is asking but nobody can be funded.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && (|rq.s_req_valid) && !gnt_any && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stat_fc_stall = stall_q;
`else
  assign stat_fc_stall = '0;
`endif

endmodule

// File: doc/pcie_fc_arb.md
PCIE_FC_ARB -- requirements
Module: pcie_fc_arb

Interface
REQ-001 Parameter PORTS, default 2: number of DMA requesters (2..8).
REQ-002 Parameter LEN_WIDTH, default 13: request byte length width.
REQ-003 Parameter PEND_WIDTH, default 12: width of the pending-credit counters.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 s_req_valid / s_req_ready  in/out  PORTS  per-port request handshake.
REQ-007 s_req_type  in  PORTS  per port: 1 = posted write, 0 = non-posted read.
REQ-008 s_req_len  in  PORTS*LEN_WIDTH  per-port payload byte count.
REQ-009 m_grant_valid / m_grant_ready  out/in  1  grant handshake to the RQ mux.
REQ-010 m_grant_port  out  clog2(PORTS)  granted port index.
REQ-011 m_grant_type / m_grant_len  out  1 / LEN_WIDTH  copy of the granted request.
REQ-012 tx_done_valid, tx_done_type, tx_done_len  in  1/1/LEN_WIDTH  pulse per transmitted TLP (from the RQ sequence-number return), releasing its reservation.
REQ-013 cfg_fc_ph, cfg_fc_pd, cfg_fc_nph  in  8/12/8  transmit credits available from the PCIe core.
REQ-014 cfg_fc_sel  out  3  constant 3'b100 (transmit credits available).
REQ-015 stat_fc_stall  out  32  credit-stall cycle count.

Function
REQ-016 Credit need: posted = 1 PH plus ceil(len/16) PD (len 0 -> 0 PD); non-posted = 1 NPH, 0 data.
REQ-017 Available credit = cfg value minus pending reservation, saturating at 0; computed at PEND_WIDTH+1 bits.
REQ-018 A port is eligible when s_req_valid=1 and every needed credit <= its available credit.
REQ-019 FSM states: IDLE, GRANT.
REQ-020 In IDLE, when any port is eligible: round-robin pick starting at rr_ptr+1 mod PORTS, register the request, add its need to pending, go to GRANT.
REQ-021 In GRANT: m_grant_valid=1 with stable fields; on m_grant_ready, pulse s_req_ready for the chosen port the same cycle, set rr_ptr = chosen port, return to IDLE.
REQ-022 Latency: eligible in cycle N -> m_grant_valid in cycle N+1. Sustained throughput is one grant per 2 cycles.
REQ-023 On tx_done_valid, subtract the released need from pending, clamped at 0 (no underflow).
REQ-024 A grant reservation and a tx_done release in the same cycle both apply: pending = pending + need - release.
REQ-025 The pending counter saturates at its max value. A request whose need exceeds the available credit waits indefinitely and does not block other ports.
REQ-026 A requester dropping s_req_valid while in GRANT does not cancel the grant; the registered request completes.

Reset
REQ-027 On rst_n=0 at a clock edge: state IDLE, rr_ptr = PORTS-1, all pending counters 0, m_grant_valid 0, s_req_ready 0, stat_fc_stall 0, m_grant_* fields 0.
REQ-028 Reset mid-GRANT drops the grant with no handshake; reservations are lost. Upstream reset of the requesters is coincident.

Configuration
REQ-029 Macro PCIE_FC_ARB_STATS_EN. When defined, stat_fc_stall increments (saturating at 2^32-1) every cycle that state is IDLE, at least one s_req_valid is high, and no port is eligible. When undefined, stat_fc_stall is tied to 0 and the counter is not synthesized.

Structure
REQ-030 Shared package pcie_fc_pkg holds: the credit-type encoding (POSTED=1, NONPOSTED=0), the FC_SEL_TX_AVAIL = 3'b100 constant, and the credit-calculation function.
REQ-031 One sub-module, pcie_fc_rr_arb: a combinational round-robin priority encoder (request vector + pointer -> one-hot grant + index).

Verification
REQ-032 Credits ph=4, pd=64, nph=4; port0 posted len=256, m_grant_ready=1 -> grant port0 next cycle; pending PH=1, PD=16.
REQ-033 pd=8; port0 posted len=256, port1 read -> port1 granted, port0 held; stall counter increments (STATS_EN defined) while port0 waits.
REQ-034 Both ports issue back-to-back reads with ample credits -> grants alternate 0,1,0,1.
REQ-035 tx_done posted len=256 in the same cycle as a new posted len=64 grant -> pending PD changes by +4-16.
REQ-036 tx_done posted len=256 with pending PD=4 -> pending PD=0, no wrap.
REQ-037 rst_n=0 during GRANT with m_grant_ready=0 -> next cycle m_grant_valid=0, all pending 0, rr_ptr=PORTS-1.
